// File: rtl/fir_fifo_uart_tx.sv
// Drains the FIR output FIFO on a send_i rising edge and sends each 16-bit word over a UART, high byte first.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1); otherwise frames are 8N1.
module fir_fifo_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DATA_W   = 16
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_i,
  input  logic              send_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rd_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, CHECK, READ, LATCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, READ, LATCH, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hi_q, hi_d;
  logic              send_q;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        byte_cur;
  logic [2:0]        bit_nxt;
  logic              bit_end;

  assign byte_cur = hi_q ? hold_q[15:8] : hold_q[7:0];
  assign bit_nxt  = bit_q + 3'd1;
  assign bit_end  = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    hold_d  = hold_q;
    hi_d    = hi_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (send_i && !send_q) begin
          state_d = CHECK;
          busy_d  = 1'b1;
        end
      end
      CHECK: begin
        if (!empty_i) begin
          state_d = READ;
          rd_d    = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      READ: state_d = LATCH;
      // FIFO data is valid the cycle after the read strobe
      LATCH: begin
        hold_d  = data_i;
        hi_d    = 1'b1;
        state_d = START;
        tx_d    = 1'b0;
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = byte_cur[0];
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^byte_cur;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = byte_cur[bit_nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      // high byte rolls straight into the low byte's start bit
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (hi_q) begin
            hi_d    = 1'b0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = CHECK;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz_i) begin
    send_q <= send_i;
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      hi_q    <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign rd_o   = rd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule
